// File: rtl/key_pkg.sv
// Shared constants and helpers for the multi-key push-button conditioner.
package key_pkg;

    localparam int unsigned DEBOUNCE_20MS_50M = 1_000_000;
    localparam int unsigned LONG_1S_50M       = 50_000_000;

    typedef enum logic {
        PolActiveHigh = 1'b0,
        PolActiveLow  = 1'b1
    } key_pol_e;

    // Bits needed to hold 0..v-1; never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x != 0; x = x >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pin / conditioned-event bundle between board pins and UI logic.
interface key_debounce_multi_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser, polarity fix, debounce window, long-press timer.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50M,
    parameter int unsigned LONG_CYCLES     = LONG_1S_50M,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DW = clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LW = clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DMax = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LMax = LW'(LONG_CYCLES - 1);
    localparam logic PinIdle = (ACTIVE_LOW == bit'(PolActiveLow));

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          fired_q, fired_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          p;
    logic          accept;

    always_comb begin
        p         = ACTIVE_LOW ? ~s2_q : s2_q;
        accept    = (p != level_q) && (dcnt_q == DMax);
        level_d   = accept ? p : level_q;
        press_d   = accept & p;
        release_d = accept & ~p;
        dcnt_d    = (p == level_q || accept) ? '0 : dcnt_q + 1'b1;

        lcnt_d  = lcnt_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        // A release accepted this edge suppresses long, so long never trails its release.
        if (!level_q || accept) begin
            lcnt_d  = '0;
            fired_d = 1'b0;
        end else if (lcnt_q != LMax) begin
            lcnt_d = lcnt_q + 1'b1;
        end else if (!fired_q) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= PinIdle;
            s2_q      <= PinIdle;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            fired_q   <= 1'b0;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
        end else begin
            s1_q      <= key_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            fired_q   <= fired_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent push-button channels, each with its own stability window.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50M,
    parameter int unsigned LONG_CYCLES     = LONG_1S_50M,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_debounce_multi_if.slave  keys
);

    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] press_w;
    logic [NUM_KEYS-1:0] release_w;
    logic [NUM_KEYS-1:0] long_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (keys.key_in[i]),
            .key_level  (level_w[i]),
            .key_press  (press_w[i]),
            .key_release(release_w[i]),
            .key_long   (long_w[i])
        );
    end

    assign keys.key_level   = level_w;
    assign keys.key_press   = press_w;
    assign keys.key_release = release_w;
    assign keys.key_long    = long_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: 3 keys, 8-cycle debounce, 32-cycle long press.
module tb_key_debounce_multi;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    int press_cnt[3]   = '{0, 0, 0};
    int release_cnt[3] = '{0, 0, 0};
    int long_cnt[3]    = '{0, 0, 0};
    int both_cnt       = 0;

    key_debounce_multi_if #(.NUM_KEYS(3)) kif ();

    key_debounce_multi #(
        .NUM_KEYS       (3),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (32),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .keys (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (kif.key_press[k])   press_cnt[k]++;
            if (kif.key_release[k]) release_cnt[k]++;
            if (kif.key_long[k])    long_cnt[k]++;
            if (kif.key_press[k] && kif.key_release[k]) both_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_level"},   32'(kif.key_level),   32'd0);
        chk({tag, "_press"},   32'(kif.key_press),   32'd0);
        chk({tag, "_release"}, 32'(kif.key_release), 32'd0);
        chk({tag, "_long"},    32'(kif.key_long),    32'd0);
    endtask

    int p0, l0, l2, p1;

    initial begin
        // 1. reset with all keys held
        rst_n      = 1'b0;
        kif.key_in = 3'b000;
        tick(3);
        chk_idle("reset");
        rst_n = 1'b1;
        tick(9);
        chk("rst_hold_press_e9", 32'(kif.key_press), 32'h0);
        chk("rst_hold_level_e9", 32'(kif.key_level), 32'h0);
        tick(1);
        chk("rst_hold_press_e10", 32'(kif.key_press), 32'h7);
        chk("rst_hold_level_e10", 32'(kif.key_level), 32'h7);
        tick(1);
        chk("rst_hold_press_e11", 32'(kif.key_press), 32'h0);
        kif.key_in = 3'b111;
        tick(10);
        chk("rst_hold_release", 32'(kif.key_release), 32'h7);
        chk("rst_hold_level_off", 32'(kif.key_level), 32'h0);
        tick(1);
        chk("rst_hold_release_e11", 32'(kif.key_release), 32'h0);

        // 2. clean press on key0
        l0 = long_cnt[0];
        kif.key_in[0] = 1'b0;
        tick(9);
        chk("clean_press_e9", 32'(kif.key_press), 32'h0);
        tick(1);
        chk("clean_press_e10", 32'(kif.key_press), 32'h1);
        chk("clean_level", 32'(kif.key_level), 32'h1);
        tick(1);
        chk("clean_press_e11", 32'(kif.key_press), 32'h0);
        kif.key_in[0] = 1'b1;
        tick(10);
        chk("clean_release", 32'(kif.key_release), 32'h1);

        // 3. bounce on key0, settle low
        p0 = press_cnt[0];
        for (int i = 0; i < 10; i++) begin
            kif.key_in[0] = (i % 2 == 1);
            tick(3);
        end
        kif.key_in[0] = 1'b0;
        tick(9);
        chk("bounce_press_e9", 32'(kif.key_press), 32'h0);
        tick(1);
        chk("bounce_press_e10", 32'(kif.key_press), 32'h1);
        tick(1);
        chk("bounce_single_press", 32'(press_cnt[0] - p0), 32'd1);
        chk("bounce_level", 32'(kif.key_level), 32'h1);
        kif.key_in[0] = 1'b1;
        tick(10);
        chk("bounce_release", 32'(kif.key_release), 32'h1);
        chk("short_no_long_k0", 32'(long_cnt[0] - l0), 32'd0);

        // 4. glitch reject on key1, then minimal accepted press
        p1 = press_cnt[1];
        kif.key_in[1] = 1'b0;
        tick(7);
        kif.key_in[1] = 1'b1;
        tick(15);
        chk("glitch7_no_press", 32'(press_cnt[1] - p1), 32'd0);
        chk("glitch7_level", 32'(kif.key_level), 32'h0);
        kif.key_in[1] = 1'b0;
        tick(8);
        kif.key_in[1] = 1'b1;
        tick(2);
        chk("glitch8_press", 32'(kif.key_press), 32'h2);
        chk("glitch8_level", 32'(kif.key_level), 32'h2);
        tick(8);
        chk("glitch8_release", 32'(kif.key_release), 32'h2);
        chk("glitch8_level_off", 32'(kif.key_level), 32'h0);

        // 5. long press on key2
        l2 = long_cnt[2];
        kif.key_in[2] = 1'b0;
        tick(10);
        chk("long_press", 32'(kif.key_press), 32'h4);
        tick(31);
        chk("long_e41", 32'(kif.key_long), 32'h0);
        tick(1);
        chk("long_e42", 32'(kif.key_long), 32'h4);
        tick(1);
        chk("long_e43", 32'(kif.key_long), 32'h0);
        tick(17);
        kif.key_in[2] = 1'b1;
        tick(9);
        chk("long_release_e9", 32'(kif.key_release), 32'h0);
        tick(1);
        chk("long_release_e10", 32'(kif.key_release), 32'h4);
        chk("long_once", 32'(long_cnt[2] - l2), 32'd1);

        // 6. short hold on key0, then reset mid-debounce on key1
        l0 = long_cnt[0];
        kif.key_in[0] = 1'b0;
        tick(20);
        kif.key_in[0] = 1'b1;
        tick(10);
        chk("hold20_release", 32'(kif.key_release), 32'h1);
        chk("hold20_no_long", 32'(long_cnt[0] - l0), 32'd0);
        p1 = press_cnt[1];
        kif.key_in[1] = 1'b0;
        tick(7);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        kif.key_in = 3'b111;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("mid_reset_no_press", 32'(press_cnt[1] - p1), 32'd0);
        chk("mid_reset_level", 32'(kif.key_level), 32'h0);
        chk("never_press_and_release", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
